// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock over a shared round datapath,
// with the round key expanded on the fly alongside the state.
module aes128_enc_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] pt_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct_out,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   fsm;
    logic [127:0] state_r;
    logic [127:0] rk_r;
    logic [3:0]   rnd;
    logic         acc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, x252;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x252 = gmul(x240, x12);
        return gmul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [7:0]   sb [16];
    logic [127:0] sr;
    logic [127:0] mc;
    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [7:0]   rcon;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] nk;
    logic [127:0] round_out;

    for (genvar n = 0; n < 16; n++) begin : g_sub_state
        assign sb[n] = sbox(state_r[127-8*n -: 8]);
    end

    // Output byte at (row r, col c) takes the substituted byte from column (c+r)%4.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign sr[127-8*(r+4*c) -: 8] = sb[r + 4*((c+r)%4)];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    assign rot_w = {rk_r[23:0], rk_r[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sub_key
        assign sub_w[31-8*j -: 8] = sbox(rot_w[31-8*j -: 8]);
    end

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign nw0       = rk_r[127:96] ^ sub_w ^ {rcon, 24'h000000};
    assign nw1       = rk_r[95:64] ^ nw0;
    assign nw2       = rk_r[63:32] ^ nw1;
    assign nw3       = rk_r[31:0] ^ nw2;
    assign nk        = {nw0, nw1, nw2, nw3};
    assign round_out = ((rnd == 4'd10) ? sr : mc) ^ nk;

    assign in_ready = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign acc      = in_valid && in_ready;
    assign busy     = (fsm == RUN);

    // A DONE-state acceptance takes priority so back-to-back blocks see no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_r   <= '0;
            rk_r      <= '0;
            rnd       <= 4'd0;
            ct_out    <= '0;
            out_valid <= 1'b0;
        end else if (acc) begin
            state_r   <= pt_in ^ key_in;
            rk_r      <= key_in;
            rnd       <= 4'd1;
            fsm       <= RUN;
            out_valid <= 1'b0;
        end else if (fsm == RUN) begin
            state_r <= round_out;
            rk_r    <= nk;
            if (rnd == 4'd10) begin
                fsm       <= DONE;
                ct_out    <= round_out;
                out_valid <= 1'b1;
            end else begin
                rnd <= rnd + 4'd1;
            end
        end else if (fsm == DONE) begin
            if (out_ready) begin
                fsm       <= IDLE;
                out_valid <= 1'b0;
            end
        end else begin
            fsm <= IDLE;
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed FIPS-197 vectors plus handshake, backpressure and reset scenarios for aes128_enc_iter.
module tb_aes128_enc_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key_in;
    logic [127:0] pt_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ct_out;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc;

    aes128_enc_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .pt_in     (pt_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct_out    (ct_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [127:0] k, input logic [127:0] p);
        in_valid = v;
        key_in   = k;
        pt_in    = p;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for out_valid; returns edges elapsed (40 means it never came).
    task automatic waitOut(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0);
        repeat (2) tick();
        checkOutput("rst_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("rst_busy", {127'd0, busy}, 128'd0);
        checkOutput("rst_ct_out", ct_out, 128'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", {127'd0, in_ready}, 128'd1);

        $display("[TB] FIPS-197 C.1 with latency check");
        applyStimulus(1'b1, C1_KEY, C1_PT);
        tick();
        in_valid = 1'b0;
        checkOutput("c1_busy_start", {127'd0, busy}, 128'd1);
        for (int i = 1; i < 10; i++) begin
            tick();
            checkOutput("c1_early_valid", {127'd0, out_valid}, 128'd0);
            checkOutput("c1_busy_run", {127'd0, busy}, 128'd1);
            checkOutput("c1_in_ready_run", {127'd0, in_ready}, 128'd0);
        end
        tick();
        checkOutput("c1_valid_at_10", {127'd0, out_valid}, 128'd1);
        checkOutput("c1_busy_done", {127'd0, busy}, 128'd0);
        checkOutput("c1_ct", ct_out, C1_CT);

        $display("[TB] Backpressure in DONE");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(i[0] ? 1'b0 : 1'b1, B_KEY, B_PT);
            #1;
            checkOutput("bp_in_ready_pre", {127'd0, in_ready}, 128'd0);
            tick();
            checkOutput("bp_ct_stable", ct_out, C1_CT);
            checkOutput("bp_out_valid", {127'd0, out_valid}, 128'd1);
            checkOutput("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        checkOutput("bp_release_still_valid", {127'd0, out_valid}, 128'd1);
        tick();
        checkOutput("bp_drop_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("bp_idle_busy", {127'd0, busy}, 128'd0);
        out_ready = 1'b0;

        $display("[TB] Back-to-back C.1 then App. B");
        applyStimulus(1'b1, C1_KEY, C1_PT);
        tick();
        applyStimulus(1'b1, B_KEY, B_PT);
        out_ready = 1'b1;
        waitOut(cyc);
        checkOutput("b2b_first_latency", 128'(cyc), 128'd10);
        checkOutput("b2b_first_ct", ct_out, C1_CT);
        checkOutput("b2b_in_ready_done", {127'd0, in_ready}, 128'd1);
        tick();
        checkOutput("b2b_valid_drop", {127'd0, out_valid}, 128'd0);
        checkOutput("b2b_second_busy", {127'd0, busy}, 128'd1);
        in_valid = 1'b0;
        waitOut(cyc);
        checkOutput("b2b_second_latency", 128'(cyc), 128'd10);
        checkOutput("b2b_second_ct", ct_out, B_CT);
        tick();
        checkOutput("b2b_idle_valid", {127'd0, out_valid}, 128'd0);
        out_ready = 1'b0;

        $display("[TB] Ignored in_valid pulse during RUN");
        applyStimulus(1'b1, C1_KEY, C1_PT);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        applyStimulus(1'b1, B_KEY, B_PT);
        #1;
        checkOutput("ign_in_ready", {127'd0, in_ready}, 128'd0);
        tick();
        in_valid = 1'b0;
        waitOut(cyc);
        checkOutput("ign_latency", 128'(cyc), 128'd6);
        checkOutput("ign_ct", ct_out, C1_CT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("[TB] Reset in RUN cycle 5");
        applyStimulus(1'b1, C1_KEY, C1_PT);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checkOutput("rr_busy_before", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rr_out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("rr_busy", {127'd0, busy}, 128'd0);
        checkOutput("rr_ct_out", ct_out, 128'd0);
        checkOutput("rr_in_ready", {127'd0, in_ready}, 128'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        checkOutput("rr_no_output", {127'd0, out_valid}, 128'd0);
        checkOutput("rr_idle_busy", {127'd0, busy}, 128'd0);
        applyStimulus(1'b1, C1_KEY, C1_PT);
        tick();
        in_valid = 1'b0;
        waitOut(cyc);
        checkOutput("rr_rerun_latency", 128'(cyc), 128'd10);
        checkOutput("rr_rerun_ct", ct_out, C1_CT);
        out_ready = 1'b1;
        tick();
        checkOutput("rr_final_idle", {127'd0, out_valid}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
